// File: rtl/tick_stopwatch.sv
// BCD mm:ss stopwatch clocked by rising edges of the divided tick_in square wave.
// Optional lap/freeze display is built when TICK_STOPWATCH_LAP_EN is defined.
module tick_stopwatch #(
  parameter int TICKS_PER_SEC = 1,
  parameter int MAX_MIN       = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef TICK_STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_active,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap,
  output logic [1:0] dbg_state
);

  // Encoding is visible on dbg_state: IDLE=0, RUN=1, PAUSE=2.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);
  localparam logic [3:0] MAX_MT    = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO    = 4'(MAX_MIN % 10);

  state_e     state_q, state_d;
  logic       tick_q;
  logic [7:0] presc_q, presc_d;
  logic [3:0] so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
  logic       running_q;
  logic       wrap_q, wrap_d;
  logic       rise, sec_inc;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    so_d    = so_q;
    st_d    = st_q;
    mo_d    = mo_q;
    mt_d    = mt_q;
    wrap_d  = 1'b0;
    sec_inc = 1'b0;
    rise    = tick_in & ~tick_q;

    // Only the state during the rise cycle decides whether it counts.
    if (rise && state_q == RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = 8'd0;
        sec_inc = 1'b1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    if (sec_inc) begin
      if (so_q != 4'd9) begin
        so_d = so_q + 4'd1;
      end else begin
        so_d = 4'd0;
        if (st_q != 4'd5) begin
          st_d = st_q + 4'd1;
        end else begin
          st_d = 4'd0;
          if (mt_q == MAX_MT && mo_q == MAX_MO) begin
            mo_d   = 4'd0;
            mt_d   = 4'd0;
            wrap_d = 1'b1;
          end else if (mo_q != 4'd9) begin
            mo_d = mo_q + 4'd1;
          end else begin
            mo_d = 4'd0;
            mt_d = mt_q + 4'd1;
          end
        end
      end
    end

    // stop outranks start even in states where stop itself does nothing.
    if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start && state_q != RUN) begin
      state_d = RUN;
    end

    if (clear) begin
      state_d = IDLE;
      presc_d = 8'd0;
      so_d    = 4'd0;
      st_d    = 4'd0;
      mo_d    = 4'd0;
      mt_d    = 4'd0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= 1'b1;
      presc_q   <= 8'd0;
      so_q      <= 4'd0;
      st_q      <= 4'd0;
      mo_q      <= 4'd0;
      mt_q      <= 4'd0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_in;
      presc_q   <= presc_d;
      so_q      <= so_d;
      st_q      <= st_d;
      mo_q      <= mo_d;
      mt_q      <= mt_d;
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
    end
  end

  assign running   = running_q;
  assign wrap      = wrap_q;
  assign dbg_state = state_q;

`ifdef TICK_STOPWATCH_LAP_EN
  logic        lap_q, lap_d;
  logic [15:0] disp_q, disp_d;

  // The snapshot is the time shown in the lap cycle, before that edge's increment.
  always_comb begin
    lap_d  = lap_q;
    disp_d = disp_q;
    if (clear) begin
      lap_d = 1'b0;
    end else if (lap && state_q == RUN) begin
      lap_d = ~lap_q;
      if (!lap_q) disp_d = {mt_q, mo_q, st_q, so_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q  <= 1'b0;
      disp_q <= 16'd0;
    end else begin
      lap_q  <= lap_d;
      disp_q <= disp_d;
    end
  end

  assign lap_active = lap_q;
  assign {min_tens, min_ones, sec_tens, sec_ones} =
    lap_q ? disp_q : {mt_q, mo_q, st_q, so_q};
`else
  assign {min_tens, min_ones, sec_tens, sec_ones} = {mt_q, mo_q, st_q, so_q};
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: two instances (1 tick/s wrapping at 01:59, 4 ticks/s at 59:59)
// share one stimulus stream; a seconds-count model feeds an expected queue.
module tb_tick_stopwatch;
  localparam int W = 21;

  logic clk = 1'b0;
  logic rst, tick_in, start, stop, clear, lap;

  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic       a_run, a_wrap, b_run, b_wrap, a_lap, b_lap;
  logic [1:0] a_state, b_state;

  always #5 clk = ~clk;

  tick_stopwatch #(.TICKS_PER_SEC(1), .MAX_MIN(1)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
`ifdef TICK_STOPWATCH_LAP_EN
    .lap(lap), .lap_active(a_lap),
`endif
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .running(a_run), .wrap(a_wrap), .dbg_state(a_state)
  );

  tick_stopwatch #(.TICKS_PER_SEC(4), .MAX_MIN(59)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
`ifdef TICK_STOPWATCH_LAP_EN
    .lap(lap), .lap_active(b_lap),
`endif
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .running(b_run), .wrap(b_wrap), .dbg_state(b_state)
  );

`ifndef TICK_STOPWATCH_LAP_EN
  assign a_lap = 1'b0;
  assign b_lap = 1'b0;
`endif

  // Model: total seconds, prescaler, state (0 idle, 1 run, 2 pause), wrap, lap, frozen time.
  int tot[2], pre[2], mst[2], mwr[2], mla[2], mfz[2];
  int tps[2]  = '{1, 4};
  int maxm[2] = '{1, 59};
  bit prev_t;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [W-1:0] pack_exp(int k);
    int v, mins;
    logic [W-1:0] r;
    v    = (mla[k] != 0) ? mfz[k] : tot[k];
    mins = v / 60;
    r = {1'(mla[k] != 0), 1'(mwr[k] != 0), 1'(mst[k] == 1), 2'(mst[k]),
         4'(mins / 10), 4'(mins % 10), 4'((v % 60) / 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic logic [W-1:0] obs(int k);
    if (k == 0) return {a_lap, a_wrap, a_run, a_state, a_mt, a_mo, a_st, a_so};
    return {b_lap, b_wrap, b_run, b_state, b_mt, b_mo, b_st, b_so};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      tot[k] = 0; pre[k] = 0; mst[k] = 0; mwr[k] = 0; mla[k] = 0; mfz[k] = 0;
      exp_q.push_back(pack_exp(k));
    end
    prev_t = 1'b1;
  endtask

  task automatic model_step(bit s, bit p, bit c, bit t, bit l);
    bit rise;
    int pst, ptot;
    rise   = t && !prev_t;
    prev_t = t;
    for (int k = 0; k < 2; k++) begin
      pst  = mst[k];
      ptot = tot[k];
      mwr[k] = 0;
      if (c) begin
        tot[k] = 0; pre[k] = 0; mst[k] = 0; mla[k] = 0;
      end else begin
        if (l && pst == 1) begin
          if (mla[k] != 0) mla[k] = 0;
          else begin mla[k] = 1; mfz[k] = ptot; end
        end
        if (rise && pst == 1) begin
          pre[k]++;
          if (pre[k] == tps[k]) begin
            pre[k] = 0;
            tot[k]++;
            if (tot[k] == (maxm[k] + 1) * 60) begin
              tot[k] = 0;
              mwr[k] = 1;
            end
          end
        end
        if (p) begin
          if (pst == 1) mst[k] = 2;
        end else if (s && pst != 1) begin
          mst[k] = 1;
        end
      end
      exp_q.push_back(pack_exp(k));
    end
  endtask

  task automatic check_pop(string tag);
    logic [W-1:0] e, o;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      o = obs(k);
      n_cmp++;
      assert (o === e) else begin
        n_mis++;
        $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, o, e);
      end
    end
  endtask

  task automatic cyc(bit s, bit p, bit c, bit t, bit l, string tag);
    @(negedge clk);
    start = s; stop = p; clear = c; tick_in = t; lap = l;
    model_step(s, p, c, t, l);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  task automatic rises(int n, string tag);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 1, 0, tag);
      cyc(0, 0, 0, 0, 0, tag);
    end
  endtask

  initial begin
    bit rs, rp, rc, rt, rl;
    rst = 1'b1; tick_in = 1'b1; start = 0; stop = 0; clear = 0; lap = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_pop("reset_state");

    // tick_in high through reset release must not count.
    cyc(1, 0, 0, 1, 0, "start_tick_high");
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, "held_high");
    cyc(0, 0, 0, 0, 0, "tick_low");
    cyc(0, 0, 0, 1, 0, "first_rise");
    cyc(0, 0, 0, 0, 0, "first_rise_after");

    // Prescaler on dut_b: 8 rises, 2 more, pause across 5 rises, resume.
    cyc(0, 0, 1, 0, 0, "clear1");
    cyc(1, 0, 0, 0, 0, "start2");
    rises(8, "presc_8");
    rises(2, "presc_2");
    cyc(0, 1, 0, 0, 0, "stop2");
    rises(5, "paused");
    cyc(1, 0, 0, 0, 0, "resume");
    rises(2, "resume_rises");

    // stop coinciding with a rise at 00:09, then start coinciding with a rise.
    cyc(0, 0, 1, 0, 0, "clear2");
    cyc(1, 0, 0, 0, 0, "start3");
    rises(9, "to_09");
    cyc(0, 1, 0, 1, 0, "stop_on_rise");
    cyc(0, 0, 0, 0, 0, "paused_low");
    cyc(1, 0, 0, 1, 0, "start_on_rise");
    cyc(0, 0, 0, 0, 0, "after_start_rise");

    // clear/stop/start together at 00:37.
    cyc(0, 0, 1, 0, 0, "clear3");
    cyc(1, 0, 0, 0, 0, "start4");
    rises(37, "to_37");
    cyc(1, 1, 1, 1, 0, "clear_all_cmds");
    cyc(0, 0, 0, 0, 0, "idle_after_clear");

    // Wrap of dut_a at 01:59.
    cyc(1, 0, 0, 0, 0, "start5");
    rises(121, "wrap_run");

    // Asynchronous reset mid-count, then no counting until start.
    rises(3, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_pop("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 1, 0, "post_rst_high");
    rises(3, "post_rst_no_start");
    cyc(1, 0, 0, 0, 0, "post_rst_start");
    rises(2, "post_rst_count");

`ifdef TICK_STOPWATCH_LAP_EN
    cyc(0, 0, 1, 0, 0, "lap_clear");
    cyc(1, 0, 0, 0, 0, "lap_start");
    rises(5, "lap_to_05");
    cyc(0, 0, 0, 0, 1, "lap_freeze");
    rises(3, "lap_frozen");
    cyc(0, 0, 0, 0, 1, "lap_release");
    cyc(0, 1, 0, 0, 1, "lap_stop");
    cyc(0, 0, 0, 0, 1, "lap_in_pause");
`endif

    // Random mix of commands and ticks.
    for (int i = 0; i < 200; i++) begin
      rt = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 5) == 0);
      rp = ($urandom_range(0, 9) == 0);
      rc = ($urandom_range(0, 40) == 0);
`ifdef TICK_STOPWATCH_LAP_EN
      rl = ($urandom_range(0, 12) == 0);
`else
      rl = 1'b0;
`endif
      cyc(rs, rp, rc, rt, rl, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/tick_stopwatch.md
Name: tick_stopwatch

Overview:
- Consumes the slow square wave produced by the clock-divider stage and detects its rising edges as count events.
- Uses those events to run a BCD mm:ss stopwatch with start/stop/clear commands.
- Outputs feed the seven-segment display driver directly downstream.

Parameters:
- TICKS_PER_SEC, default 1: rising edges of tick_in per one-second increment; legal range 1..255.
- MAX_MIN, default 59: highest minute value before wrap; legal range 1..99.

Ports:
- clk  in  1  system clock; same domain as the divider output.
- rst  in  1  asynchronous, active-high reset.
- tick_in  in  1  divided square wave from the clock-divider stage.
- start  in  1  start/resume command, sampled each clk.
- stop  in  1  pause command, sampled each clk.
- clear  in  1  zero the time and return to IDLE, sampled each clk.
- sec_ones  out  4  BCD seconds units, 0..9.
- sec_tens  out  4  BCD seconds tens, 0..5.
- min_ones  out  4  BCD minutes units.
- min_tens  out  4  BCD minutes tens.
- running  out  1  high while in state RUN.
- wrap  out  1  one-cycle pulse when the time rolls MAX_MIN:59 -> 00:00.

Behaviour:
- Clock and reset
  - Interface: one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Reset values
  - All BCD digits 0, running 0, wrap 0.
  - State IDLE, prescaler 0.
  - Edge register tick_d = 1, so a tick_in already high at reset release is not counted.
- Edge detect
  - rise = tick_in & ~tick_d, evaluated combinationally; tick_d <= tick_in every cycle.
  - A rise is recognised only in the cycle where tick_in is first sampled high.
  - A level held high never produces a second rise.
- Prescaler
  - Counts 0..TICKS_PER_SEC-1 on each rise while in RUN.
  - A rise with the prescaler at TICKS_PER_SEC-1 resets it to 0 and issues one second-increment.
  - With TICKS_PER_SEC=1, every rise increments.
- State machine (IDLE, RUN, PAUSE)
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE; start is ignored.
  - PAUSE: start -> RUN; stop is ignored.
  - Any state: clear -> IDLE, with digits and prescaler zeroed at the same edge.
  - Priority when simultaneous: clear > stop > start.
  - running = (state == RUN), registered.
- Counting and latency
  - The increment is applied at the clk edge ending the rise cycle, so new digits are visible 1 cycle after tick_in is first sampled high.
  - A rise counts only if the state is RUN during the rise cycle:
    - stop in the same cycle as a rise while in RUN: the rise is counted.
    - start in the same cycle as a rise while in PAUSE/IDLE: the rise is not counted.
  - clear in the same cycle as a rise: clear wins; result is 00:00.
  - A pause preserves the prescaler value.
- BCD cascade
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into minutes.
  - min_ones 9->0 carries into min_tens.
  - At MAX_MIN:59 the next increment yields 00:00, wrap=1 for exactly one cycle, and counting continues in RUN.
  - Digits never hold a non-BCD value.
- Reset mid-operation
  - Asserting rst at any time immediately forces the reset values.
  - Counting resumes only after release plus a start command.

Optional Feature:
- Macro: TICK_STOPWATCH_LAP_EN.
- Defined:
  - Adds input lap (1 bit) and output lap_active (1 bit).
  - A lap pulse while in RUN latches the current digits into display registers and sets lap_active=1. The BCD outputs show the frozen value while internal counting continues.
  - A second lap pulse, or clear, releases the freeze and sets lap_active=0. The outputs show live time from the next cycle.
  - lap in IDLE or PAUSE is ignored.
  - Reset clears lap_active.
- Undefined:
  - Neither port exists.
  - The BCD outputs always reflect live time, with identical timing to the defined build when not frozen.

Test Plan:
- Reset with tick_in=1, release, start, then hold tick_in high 10 cycles -> digits stay 00:00; first low->high transition gives 00:01 one cycle later.
- TICKS_PER_SEC=4, start, 8 rises -> 00:02; stop after 2 further rises; 5 rises while paused -> still 00:02; start, 2 rises -> 00:03.
- MAX_MIN=1, run to 01:59, one increment -> 00:00, wrap high for exactly 1 cycle, running stays 1.
- stop coinciding with a rise at 00:09 -> 00:10 and state PAUSE; start coinciding with a rise -> no increment that cycle.
- clear, stop and start asserted together at 00:37 -> 00:00, state IDLE, running 0; rst mid-count -> all outputs 0 asynchronously.
- With TICK_STOPWATCH_LAP_EN: lap at 00:05, 3 increments -> outputs hold 00:05, lap_active 1; second lap -> 00:08 next cycle, lap_active 0.
